pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Fetch-side controller that owns the program counter and sequences the instruction-memory handshake for the pipelined CPU. Each cycle it picks the next PC: sequential (+4), a branch/jump redirect from EX/MEM, or a JALR target. It also drives the fetch request and flushes younger pipeline stages on a redirect. A pending redirect is held while an instruction fetch is still in flight, so a wait-stated memory never sees its address change mid-request.

## Interface
Parameters:
- `RESET_PC`, default `32'h0000_0000`: PC loaded on reset.
- `TRAP_VEC`, default `32'h0000_0100`: redirect target for misaligned targets; used only with `PC_MISALIGN_TRAP_EN`.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset; **synchronous, active-high**.
- `stall`  in  1  hazard-unit stall; hold PC and do not deliver a fetch.
- `redirect_op`  in  3  NPC operation from EX/MEM: `NPC_PLUS4`/`NPC_BRANCH`/`NPC_JUMP`/`NPC_JALR` from `ctrl_encode_def.v`.
- `redirect_base`  in  32  PC of the redirecting instruction.
- `redirect_imm`  in  32  branch/jump offset.
- `redirect_alu`  in  32  JALR target from the ALU.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address, always equal to `pc`.
- `imem_ack`  in  1  fetch completes this cycle.
- `pc`  out  32  current fetch PC, registered.
- `fetch_valid`  out  1  instruction on the imem data bus is accepted into IF/ID this cycle.
- `flush`  out  1  kill IF/ID, ID/EX and EX/MEM contents this cycle.
- `misalign`  out  1  misaligned redirect target detected; constant 0 without `PC_MISALIGN_TRAP_EN`.

## Operation
- A redirect is active when `redirect_op` is not `NPC_PLUS4`. Any unknown encoding is treated as `NPC_PLUS4`.
- Target computation:
  - `NPC_BRANCH` and `NPC_JUMP`: `redirect_base + redirect_imm`, modulo 2^32.
  - `NPC_JALR`: `redirect_alu & ~32'h1`.
- Redirect priority: redirect > stall > sequential.
- FSM states:
  - **BOOT**: entered on reset. `imem_req`=0. Moves to FETCH next cycle. Redirects arriving in BOOT are ignored.
  - **FETCH**: `imem_req`=1.
    - Ack, no redirect, no stall: `fetch_valid`=1, `pc`<=`pc`+4 (wraps at 2^32).
    - Ack with stall: `fetch_valid`=0, `pc` held, same address re-requested next cycle.
    - Redirect with ack: response dropped (`fetch_valid`=0), `pc`<=target, stay in FETCH.
    - Redirect without ack: `pend_pc`<=target, go to DISCARD.
  - **DISCARD**: `imem_req`=1 with the old address held stable; `fetch_valid`=0.
    - On ack: `pc`<=`pend_pc`, go to FETCH.
    - A new redirect here overwrites `pend_pc`; the newest redirect wins.
- `flush` is combinational and equals redirect-active in FETCH or DISCARD. It is 0 in BOOT and while `rst`=1.
- `fetch_valid` = (state==FETCH) & `imem_ack` & ~`stall` & ~redirect.
- Handshake rule: once `imem_req` is raised, `imem_addr` holds stable until `imem_ack`. Only reset may drop a request early, and imem must tolerate that.

## Timing
- Reset values: `pc`=`RESET_PC`, state=BOOT, `pend_pc`=0, `imem_req`=0, `fetch_valid`=0, `flush`=0, `misalign`=0.
- First request goes out 1 cycle after `rst` deasserts.
- With a zero-wait memory (ack in the same cycle as the request), throughput is 1 fetch per cycle.
- Redirect with same-cycle ack: the target appears on `imem_addr` the next cycle.
- Redirect during a wait: the target appears the cycle after the outstanding ack.
- `rst` in DISCARD or in the middle of a request abandons the pending state immediately. The next cycle is BOOT with reset values.
- Simultaneous redirect and stall: the redirect is taken and the stall is ignored for PC purposes.

## Configuration
- `PC_MISALIGN_TRAP_EN` defined:
  - A redirect whose target has bits[1:0] ≠ 0 uses `TRAP_VEC` as the target.
  - `misalign` pulses for 1 cycle, in the same cycle as `flush`.
- `PC_MISALIGN_TRAP_EN` undefined:
  - Targets are used unchanged.
  - `misalign` is tied to 0.

## Test plan
- Reset, zero-wait memory, no redirects: `pc` = 0, 4, 8, 12 on consecutive cycles after BOOT; `fetch_valid`=1 each cycle.
- `NPC_BRANCH` with base=0x40, imm=0xFFFFFFF8, ack same cycle: `flush`=1, `fetch_valid`=0, next `imem_addr`=0x38.
- 3-wait memory, `NPC_JALR` with alu=0x105 on wait cycle 1:
  - `imem_addr` stays at the old PC until ack.
  - Next request goes to 0x104.
  - `fetch_valid` never asserts for the dropped response.
- Two redirects during one DISCARD (targets 0x200, then 0x300): the fetch after the ack goes to 0x300; `flush` pulses twice.
- `stall`=1 for 2 cycles with ack: `pc` held, address re-requested, `fetch_valid`=0; resumes +4 once stall drops.
- With `PC_MISALIGN_TRAP_EN`: `NPC_JUMP` target 0x102 gives `misalign`=1, `flush`=1 and next `pc`=0x100. Without the macro: next `pc`=0x102 and `misalign`=0.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch handshake between pc_sequencer (master) and imem (slave).
// Once imem_req rises, imem_addr stays stable until imem_ack.
interface pc_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-side PC owner: chooses sequential/branch/jump/JALR next PC and sequences the imem handshake.
// Optional feature macro PC_MISALIGN_TRAP_EN: misaligned redirect targets are replaced by TRAP_VEC.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic [2:0]            redirect_op,
    input  logic [31:0]           redirect_base,
    input  logic [31:0]           redirect_imm,
    input  logic [31:0]           redirect_alu,
    pc_sequencer_if.master        imem,
    output logic [31:0]           pc,
    output logic                  fetch_valid,
    output logic                  flush,
    output logic                  misalign
);

    localparam logic [2:0] NPC_PLUS4  = 3'b000;
    localparam logic [2:0] NPC_BRANCH = 3'b001;
    localparam logic [2:0] NPC_JUMP   = 3'b010;
    localparam logic [2:0] NPC_JALR   = 3'b100;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_FETCH,
        ST_DISCARD
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_pc_q, pend_pc_d;

    logic        redir_active;
    logic [31:0] raw_target;
    logic        target_misaligned;
    logic [31:0] target;

    // Unknown encodings fall through to sequential (no redirect).
    always_comb begin
        redir_active = 1'b0;
        raw_target   = '0;
        case (redirect_op)
            NPC_BRANCH,
            NPC_JUMP: begin
                redir_active = 1'b1;
                raw_target   = redirect_base + redirect_imm;
            end
            NPC_JALR: begin
                redir_active = 1'b1;
                raw_target   = redirect_alu & ~32'h1;
            end
            default: begin
                redir_active = 1'b0;
                raw_target   = '0;
            end
        endcase
    end

`ifdef PC_MISALIGN_TRAP_EN
    assign target_misaligned = redir_active && (raw_target[1:0] != 2'b00);
    assign target            = target_misaligned ? TRAP_VEC : raw_target;
`else
    logic unused_trap_vec;
    assign unused_trap_vec   = ^TRAP_VEC;
    assign target_misaligned = 1'b0;
    assign target            = raw_target;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_BOOT;
            pc_q      <= RESET_PC;
            pend_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    // All outputs are forced low while rst is high so a request can be abandoned immediately.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_pc_d     = pend_pc_q;
        imem.imem_req = 1'b0;
        fetch_valid   = 1'b0;
        flush         = 1'b0;
        misalign      = 1'b0;

        unique case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                imem.imem_req = !rst;
                if (redir_active) begin
                    flush    = !rst;
                    misalign = !rst && target_misaligned;
                    if (imem.imem_ack) begin
                        pc_d = target;
                    end else begin
                        pend_pc_d = target;
                        state_d   = ST_DISCARD;
                    end
                end else if (imem.imem_ack && !stall) begin
                    fetch_valid = !rst;
                    pc_d        = pc_q + 32'd4;
                end
            end

            ST_DISCARD: begin
                imem.imem_req = !rst;
                if (redir_active) begin
                    flush     = !rst;
                    misalign  = !rst && target_misaligned;
                    pend_pc_d = target;
                end
                // A redirect coinciding with the ack still wins over the older pending target.
                if (imem.imem_ack) begin
                    pc_d    = redir_active ? target : pend_pc_q;
                    state_d = ST_FETCH;
                end
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    assign imem.imem_addr = pc_q;
    assign pc             = pc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer with hand-computed expectations.
// Expectations for the misaligned-jump case follow PC_MISALIGN_TRAP_EN.
module tb_pc_sequencer;

    localparam logic [2:0] OP_PLUS4  = 3'b000;
    localparam logic [2:0] OP_BRANCH = 3'b001;
    localparam logic [2:0] OP_JUMP   = 3'b010;
    localparam logic [2:0] OP_JALR   = 3'b100;
    localparam logic [2:0] OP_BOGUS  = 3'b111;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [2:0]  redirect_op;
    logic [31:0] redirect_base;
    logic [31:0] redirect_imm;
    logic [31:0] redirect_alu;
    logic [31:0] pc;
    logic        fetch_valid;
    logic        flush;
    logic        misalign;

    int unsigned total = 0;
    int unsigned bad   = 0;

    pc_sequencer_if imem_bus ();

    pc_sequencer #(
        .RESET_PC (32'h0000_0000),
        .TRAP_VEC (32'h0000_0100)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .redirect_op   (redirect_op),
        .redirect_base (redirect_base),
        .redirect_imm  (redirect_imm),
        .redirect_alu  (redirect_alu),
        .imem          (imem_bus.master),
        .pc            (pc),
        .fetch_valid   (fetch_valid),
        .flush         (flush),
        .misalign      (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Waits for the next rising edge, applies one vector, and settles before checks.
    task automatic cyc(input logic r, input logic st, input logic [2:0] op,
                       input logic [31:0] base, input logic [31:0] imm,
                       input logic [31:0] alu, input logic ack);
        @(posedge clk);
        #1;
        rst                    = r;
        stall                  = st;
        redirect_op            = op;
        redirect_base          = base;
        redirect_imm           = imm;
        redirect_alu           = alu;
        imem_bus.imem_ack      = ack;
        #1;
    endtask

    // Checks request, address, fetch_valid and flush in one go.
    task automatic expect_io(input string tag, input logic req, input logic [31:0] addr,
                             input logic fv, input logic fl);
        check({tag, ".req"},   {31'b0, imem_bus.imem_req}, {31'b0, req});
        check({tag, ".addr"},  imem_bus.imem_addr, addr);
        check({tag, ".fv"},    {31'b0, fetch_valid}, {31'b0, fv});
        check({tag, ".flush"}, {31'b0, flush}, {31'b0, fl});
    endtask

    initial begin
        rst               = 1'b1;
        stall             = 1'b0;
        redirect_op       = OP_PLUS4;
        redirect_base     = '0;
        redirect_imm      = '0;
        redirect_alu      = '0;
        imem_bus.imem_ack = 1'b0;

        // Reset held; a redirect during reset must not flush.
        cyc(1'b1, 1'b0, OP_JUMP, 32'h0, 32'h40, 32'h0, 1'b1);
        expect_io("rst", 1'b0, 32'h0, 1'b0, 1'b0);
        check("rst.pc", pc, 32'h0);
        check("rst.mis", {31'b0, misalign}, 32'h0);

        // BOOT: no request, redirect ignored.
        cyc(1'b0, 1'b0, OP_BRANCH, 32'h40, 32'h10, 32'h0, 1'b1);
        expect_io("boot", 1'b0, 32'h0, 1'b0, 1'b0);

        // Zero-wait sequential fetches.
        cyc(1'b0, 1'b0, OP_PLUS4, 32'h0, 32'h0, 32'h0, 1'b1);
        expect_io("seq0", 1'b1, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, OP_PLUS4, 32'h0, 32'h0, 32'h0, 1'b1);
        expect_io("seq1", 1'b1, 32'h4, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, OP_PLUS4, 32'h0, 32'h0, 32'h0, 1'b1);
        expect_io("seq2", 1'b1, 32'h8, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, OP_PLUS4, 32'h0, 32'h0, 32'h0, 1'b1);
        expect_io("seq3", 1'b1, 32'hC, 1'b1, 1'b0);

        // Branch with same-cycle ack: 0x40 + (-8) = 0x38.
        cyc(1'b0, 1'b0, OP_BRANCH, 32'h40, 32'hFFFF_FFF8, 32'h0, 1'b1);
        expect_io("br", 1'b1, 32'h10, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, OP_PLUS4, 32'h0, 32'h0, 32'h0, 1'b1);
        expect_io("br.tgt", 1'b1, 32'h38, 1'b1, 1'b0);

        // 3-wait memory, JALR 0x105 -> 0x104 on wait cycle 1.
        cyc(1'b0, 1'b0, OP_JALR, 32'h0, 32'h0, 32'h105, 1'b0);
        expect_io("jalr.w1", 1'b1, 32'h3C, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, OP_PLUS4, 32'h0, 32'h0, 32'h0, 1'b0);
        expect_io("jalr.w2", 1'b1, 32'h3C, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, OP_PLUS4, 32'h0, 32'h0, 32'h0, 1'b0);
        expect_io("jalr.w3", 1'b1, 32'h3C, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, OP_PLUS4, 32'h0, 32'h0, 32'h0, 1'b1);
        expect_io("jalr.ack", 1'b1, 32'h3C, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, OP_PLUS4, 32'h0, 32'h0, 32'h0, 1'b1);
        expect_io("jalr.tgt", 1'b1, 32'h104, 1'b1, 1'b0);

        // Two redirects in one DISCARD: 0x200 then 0x300; newest wins.
        cyc(1'b0, 1'b0, OP_JUMP, 32'h100, 32'h100, 32'h0, 1'b0);
        expect_io("dd.r1", 1'b1, 32'h108, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, OP_BRANCH, 32'h300, 32'h0, 32'h0, 1'b0);
        expect_io("dd.r2", 1'b1, 32'h108, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, OP_PLUS4, 32'h0, 32'h0, 32'h0, 1'b1);
        expect_io("dd.ack", 1'b1, 32'h108, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, OP_PLUS4, 32'h0, 32'h0, 32'h0, 1'b1);
        expect_io("dd.tgt", 1'b1, 32'h300, 1'b1, 1'b0);

        // Stall for 2 cycles with ack: address re-requested, no delivery.
        cyc(1'b0, 1'b1, OP_PLUS4, 32'h0, 32'h0, 32'h0, 1'b1);
        expect_io("st1", 1'b1, 32'h304, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, OP_PLUS4, 32'h0, 32'h0, 32'h0, 1'b1);
        expect_io("st2", 1'b1, 32'h304, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, OP_PLUS4, 32'h0, 32'h0, 32'h0, 1'b1);
        expect_io("st.go", 1'b1, 32'h304, 1'b1, 1'b0);

        // Redirect beats stall.
        cyc(1'b0, 1'b1, OP_JUMP, 32'h0, 32'h500, 32'h0, 1'b1);
        expect_io("rs", 1'b1, 32'h308, 1'b0, 1'b1);

        // Unknown encoding behaves as sequential.
        cyc(1'b0, 1'b0, OP_BOGUS, 32'h0, 32'h40, 32'h0, 1'b1);
        expect_io("bogus", 1'b1, 32'h500, 1'b1, 1'b0);

        // Misaligned jump target 0x102.
        cyc(1'b0, 1'b0, OP_JUMP, 32'h100, 32'h2, 32'h0, 1'b1);
        expect_io("mis", 1'b1, 32'h504, 1'b0, 1'b1);
`ifdef PC_MISALIGN_TRAP_EN
        check("mis.flag", {31'b0, misalign}, 32'h1);
`else
        check("mis.flag", {31'b0, misalign}, 32'h0);
`endif
        cyc(1'b0, 1'b0, OP_PLUS4, 32'h0, 32'h0, 32'h0, 1'b1);
`ifdef PC_MISALIGN_TRAP_EN
        check("mis.pc", pc, 32'h100);
`else
        check("mis.pc", pc, 32'h102);
`endif
        check("mis.clr", {31'b0, misalign}, 32'h0);

        // PC wraps at 2^32: JALR 0xFFFFFFFD -> 0xFFFFFFFC, then +4 -> 0.
        cyc(1'b0, 1'b0, OP_JALR, 32'h0, 32'h0, 32'hFFFF_FFFD, 1'b1);
        check("wrap.fl", {31'b0, flush}, 32'h1);
        cyc(1'b0, 1'b0, OP_PLUS4, 32'h0, 32'h0, 32'h0, 1'b1);
        expect_io("wrap.top", 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, OP_PLUS4, 32'h0, 32'h0, 32'h0, 1'b0);
        expect_io("wrap.zero", 1'b1, 32'h0, 1'b0, 1'b0);

        // Reset during DISCARD abandons the pending target.
        cyc(1'b0, 1'b0, OP_JUMP, 32'h700, 32'h0, 32'h0, 1'b0);
        expect_io("rd.r", 1'b1, 32'h0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, OP_JUMP, 32'h800, 32'h0, 32'h0, 1'b1);
        expect_io("rd.rst", 1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, OP_PLUS4, 32'h0, 32'h0, 32'h0, 1'b1);
        expect_io("rd.boot", 1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, OP_PLUS4, 32'h0, 32'h0, 32'h0, 1'b1);
        expect_io("rd.fetch", 1'b1, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, OP_PLUS4, 32'h0, 32'h0, 32'h0, 1'b0);
        expect_io("rd.next", 1'b1, 32'h4, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
